// File: rtl/conv_accumulator.sv
// Sums (a + b) over groups of N_TERMS accepted beats into a signed ACC_W result.
// Latency: result registered 1 cycle after the last beat of a group is accepted.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls input.
module conv_accumulator #(
  parameter int DATA_W   = 8,   // signed operand width
  parameter int ACC_W    = 16,  // signed accumulator/result width, >= DATA_W+1
  parameter int N_TERMS  = 4,   // beats per group, >= 1
  parameter int SATURATE = 1    // 1: clamp on overflow, 0: wrap modulo 2^ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_sat
);

  // Counter is at least one bit wide so N_TERMS=1 still elaborates cleanly.
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  // Working width: two guard bits above the accumulator so acc + p never wraps.
  localparam int WW    = ACC_W + 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_LAST  = 1'b1;
  // A single-beat group makes every beat the last one.
  localparam logic [0:0] ST_INIT  = (N_TERMS == 1) ? ST_LAST : ST_ACCUM;

  localparam bit SAT_EN = (SATURATE != 0);

  // Clamp limits expressed directly in the accumulator width.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // State and datapath registers.
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             flag_q,      flag_d;
  logic [0:0]       state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q,   out_sum_d;
  logic             out_sat_q,   out_sat_d;

  // Datapath intermediates.
  logic [DATA_W:0]  p_w;
  logic [WW-1:0]    p_ext;
  logic [WW-1:0]    acc_ext;
  logic [WW-1:0]    sum_w;
  logic [2:0]       sum_hi;
  logic             sum_fits;
  logic             clamp;
  logic [ACC_W-1:0] acc_next;
  logic             accept;
  logic             is_last;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !clr;
  assign is_last  = (state_q == ST_LAST);

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

  // Beat sum at full DATA_W+1 precision, then sign-extend both addends to WW.
  always_comb begin
    p_w     = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    p_ext   = {{(WW-DATA_W-1){p_w[DATA_W]}}, p_w};
    acc_ext = {{2{acc_q[ACC_W-1]}}, acc_q};
    sum_w   = acc_ext + p_ext;
  end

  // Overflow detection and clamp/wrap of the running sum.
  always_comb begin
    // The sum fits in ACC_W bits iff the three top bits are a pure sign extension.
    sum_hi   = sum_w[WW-1:ACC_W-1];
    sum_fits = (&sum_hi) || !(|sum_hi);
    clamp    = 1'b0;
    acc_next = sum_w[ACC_W-1:0];
    if (SAT_EN && !sum_fits) begin
      clamp    = 1'b1;
      acc_next = sum_w[WW-1] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state: clr wins over everything, then group completion, then output drain.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;

    if (clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      flag_d      = 1'b0;
      state_d     = ST_INIT;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (is_last) begin
          // Group done: publish the result (including this beat's clamp) and restart.
          out_sum_d   = acc_next;
          out_sat_d   = flag_q || clamp;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          flag_d      = 1'b0;
          state_d     = ST_INIT;
        end else begin
          acc_d   = acc_next;
          cnt_d   = cnt_q + CNT_ONE;
          flag_d  = flag_q || clamp;
          state_d = ((cnt_q + CNT_ONE) == CNT_LAST) ? ST_LAST : ST_ACCUM;
        end
      end
    end
  end

  // Register update with asynchronous reset of all state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      state_q     <= ST_INIT;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: one 16-bit instance plus two 10-bit
// instances (saturating and wrapping) sharing the same stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_conv_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clr, in_valid, out_ready;
  logic signed [7:0] a, b;

  logic              in_ready, out_valid, out_sat;
  logic signed [15:0] out_sum;
  logic              in_ready_s, out_valid_s, out_sat_s;
  logic signed [9:0] out_sum_s;
  logic              in_ready_w, out_valid_w, out_sat_w;
  logic signed [9:0] out_sum_w;

  int n_cmp = 0;
  int n_err = 0;

  conv_accumulator #(.DATA_W(8), .ACC_W(16), .N_TERMS(4), .SATURATE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat)
  );

  conv_accumulator #(.DATA_W(8), .ACC_W(10), .N_TERMS(4), .SATURATE(1)) u_sat10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_sat(out_sat_s)
  );

  conv_accumulator #(.DATA_W(8), .ACC_W(10), .N_TERMS(4), .SATURATE(0)) u_wrap10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_sum(out_sum_w), .out_sat(out_sat_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int av, input int bv, input logic c);
    a        = 8'(av);
    b        = 8'(bv);
    in_valid = 1'b1;
    clr      = c;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    clr      = 1'b0;
    cyc();
  endtask

  int results;
  int exp_v;

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state, with out_ready low to show in_ready is still 1.
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_out_sat",   int'(out_sat),   0);
    chk("rst_in_ready",  int'(in_ready),  1);
    #5;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc();

    // Basic sum: 15 - 5 + 254 - 128 = 136.
    beat(10, 5, 1'b0);
    chk("basic_vld_b1", int'(out_valid), 0);
    beat(-3, -2, 1'b0);
    chk("basic_vld_b2", int'(out_valid), 0);
    beat(127, 127, 1'b0);
    chk("basic_vld_b3", int'(out_valid), 0);
    beat(-128, 0, 1'b0);
    chk("basic_vld", int'(out_valid), 1);
    chk("basic_sum", int'(out_sum),   136);
    chk("basic_sat", int'(out_sat),   0);
    idle();
    chk("basic_vld_drop", int'(out_valid), 0);

    // Saturation: 4 x 254. ACC_W=10 clamps at 511 or wraps 1016 -> -8.
    for (int i = 0; i < 4; i++) beat(127, 127, 1'b0);
    chk("sat10_vld",  int'(out_valid_s), 1);
    chk("sat10_sum",  int'(out_sum_s),   511);
    chk("sat10_flag", int'(out_sat_s),   1);
    chk("wrap10_sum", int'(out_sum_w),   -8);
    chk("wrap10_flag", int'(out_sat_w),  0);
    chk("acc16_sum",  int'(out_sum),     1016);
    chk("acc16_flag", int'(out_sat),     0);
    idle();

    // Backpressure: finish a group (sum 4) with out_ready low, then stall.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1, 0, 1'b0);
    chk("bp_vld",      int'(out_valid), 1);
    chk("bp_sum",      int'(out_sum),   4);
    chk("bp_in_ready", int'(in_ready),  0);
    beat(2, 0, 1'b0);
    chk("bp_hold_vld1", int'(out_valid), 1);
    chk("bp_hold_sum1", int'(out_sum),   4);
    beat(2, 0, 1'b0);
    chk("bp_hold_vld2", int'(out_valid), 1);
    chk("bp_hold_sum2", int'(out_sum),   4);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_up", int'(in_ready), 1);
    // Stalled beats were dropped: this group needs four fresh beats of 2.
    beat(2, 0, 1'b0);
    chk("bp_drain_vld", int'(out_valid), 0);
    beat(2, 0, 1'b0);
    beat(2, 0, 1'b0);
    chk("bp_next_vld_b3", int'(out_valid), 0);
    beat(2, 0, 1'b0);
    chk("bp_next_vld", int'(out_valid), 1);
    chk("bp_next_sum", int'(out_sum),   8);
    idle();

    // Streaming: 12 beats of (1,1) -> a result of 8 every fourth cycle.
    results = 0;
    for (int i = 0; i < 12; i++) begin
      a        = 8'sd1;
      b        = 8'sd1;
      in_valid = 1'b1;
      clr      = 1'b0;
      #1;
      chk("stream_in_ready", int'(in_ready), 1);
      cyc();
      exp_v = ((i % 4) == 3) ? 1 : 0;
      chk("stream_vld", int'(out_valid), exp_v);
      if (out_valid) begin
        results++;
        chk("stream_sum", int'(out_sum), 8);
      end
    end
    chk("stream_count", results, 3);
    idle();

    // Reset mid-group discards the partial sum.
    beat(50, 50, 1'b0);
    beat(50, 50, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("midrst_vld",      int'(out_valid), 0);
    chk("midrst_sum",      int'(out_sum),   0);
    chk("midrst_in_ready", int'(in_ready),  1);
    #1;
    rst_n = 1'b1;
    cyc();
    beat(1, 2, 1'b0);
    beat(1, 2, 1'b0);
    chk("midrst_vld_b2", int'(out_valid), 0);
    beat(1, 2, 1'b0);
    beat(1, 2, 1'b0);
    chk("midrst_res_vld", int'(out_valid), 1);
    chk("midrst_res_sum", int'(out_sum),   12);
    idle();

    // clr on the last beat aborts the group; the next group starts clean.
    beat(1, 1, 1'b0);
    beat(1, 1, 1'b0);
    beat(1, 1, 1'b0);
    beat(1, 1, 1'b1);
    chk("clr_last_vld", int'(out_valid), 0);
    beat(2, 2, 1'b0);
    beat(2, 2, 1'b0);
    beat(2, 2, 1'b0);
    chk("clr_next_vld_b3", int'(out_valid), 0);
    beat(2, 2, 1'b0);
    chk("clr_next_vld", int'(out_valid), 1);
    chk("clr_next_sum", int'(out_sum),   16);

    // clr drops a held result even while the consumer is stalled.
    out_ready = 1'b0;
    beat(3, 3, 1'b1);
    chk("clr_held_vld", int'(out_valid), 0);
    out_ready = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
